gate_sweep_checker: RTL
=======================

# gate_sweep_checker

Self-checking stimulus and response stage for the two-input basic-gate block. On `start`, it drives the gate block's `a`/`b` inputs through all four combinations in the order 00, 01, 10, 11. It samples the seven gate outputs after a programmable settle time, compares them against internally computed expected values, and reports a pass/fail verdict plus an error count. It sits directly around the gate block: `a_o`/`b_o` feed the gate block, and the gate outputs return on `gate_in`.

## Interface
- `SETTLE`, default 2: cycles a vector is held before its sampling cycle; legal range 1..15.
- `ERR_W`, default 3: width of `err_cnt`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: request a sweep; honoured only in IDLE.
- `gate_in` input 7: gate outputs from the gate block; bit 0 and, 1 or, 2 nand, 3 nor, 4 xor, 5 xnor, 6 not (not of `a`).
- `a_o` output 1: registered `a` stimulus.
- `b_o` output 1: registered `b` stimulus.
- `busy` output 1: high in SETTLE and CHECK.
- `done` output 1: one-cycle pulse at sweep end.
- `pass` output 1: verdict of the last completed sweep; high iff `err_cnt` is 0.
- `err_cnt` output ERR_W: number of vectors with at least one mismatching bit; saturates at all-ones.
- `fail_mask` output 7: sticky per-gate mismatch flags. Present only with GATE_CHK_MASK_EN.

## Operation
- Reset value of every output is 0. This includes `pass`, so no verdict is reported until the first sweep completes.
- FSM states are IDLE, SETTLE, CHECK and DONE.
- **IDLE**
  - `start`=1 moves to SETTLE.
  - On the same edge: `{a_o,b_o}` <= 2'b00, vector index `vec` <= 0, settle counter <= 0, `err_cnt` <= 0, `pass` <= 0, `fail_mask` <= 0.
- **SETTLE**
  - Counter increments each cycle.
  - When the counter reaches SETTLE-1, moves to CHECK.
- **CHECK**
  - Samples `gate_in` and compares it with `exp`.
  - `exp` = {~a, ~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b}, computed from the registered `a_o`/`b_o`.
  - If any bit differs, `err_cnt` increments unless it is already all-ones.
  - `fail_mask` is ORed with (`gate_in` ^ `exp`).
  - If `vec`<3: `vec` increments, `{a_o,b_o}` <= `vec`+1, counter <= 0, moves to SETTLE.
  - If `vec`==3: moves to DONE.
- **DONE** (lasts one cycle)
  - `done`=1.
  - `pass` registered as (`err_cnt`==0), including the final vector's result.
  - `{a_o,b_o}` <= 00. Moves to IDLE.
- **Held values:** `err_cnt`, `pass` and `fail_mask` hold until the next accepted `start`.
- **Ignored `start`:** `start` in SETTLE, CHECK or DONE is ignored, not queued.
- **Reset mid-sweep:** `rst_n` low at any time forces IDLE and zeroes all outputs immediately. Partial results are discarded.

## Timing
- Each vector is driven for SETTLE+1 cycles (SETTLE cycles in SETTLE plus one in CHECK).
- Sampling happens at the edge ending its CHECK cycle.
- With `start` accepted at edge T0:
  - Vector n is applied from T0+n·(SETTLE+1).
  - Vector n is sampled at T0+n·(SETTLE+1)+SETTLE+1.
  - DONE is entered at T0+4·(SETTLE+1).
  - `done`, and the final `pass`/`err_cnt`, are valid in the cycle following that edge.
- Default SETTLE=2 gives 12 cycles from the `start` edge to `done`.
- `busy` rises on the cycle after the `start` edge and falls when DONE is entered.
- The gate block is combinational, so its settling in 1 cycle is sufficient. Larger SETTLE values are for a registered gate block.

## Configuration
- `GATE_CHK_MASK_EN` defined:
  - The `fail_mask` port and its register exist.
  - The sticky per-gate OR is accumulated in CHECK and cleared on accepted `start` and on reset.
- `GATE_CHK_MASK_EN` undefined:
  - The port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- **Correct gate model, SETTLE=2, one `start` pulse:**
  - `a_o`/`b_o` sequence 00,01,10,11, each held 3 cycles.
  - `done` high exactly 12 cycles after the start edge.
  - `pass`=1, `err_cnt`=0, `fail_mask`=7'h00.
- **xor output stuck at 0:**
  - Vectors 01 and 10 fail.
  - `err_cnt`=2, `pass`=0, `fail_mask`=7'h10.
- **All seven outputs inverted, ERR_W=2:**
  - Every vector fails, and the counter saturates.
  - `err_cnt`=3, `pass`=0, `fail_mask`=7'h7F.
- **Extra `start` pulses while busy:**
  - `start` re-pulsed at cycles 4 and 11 after the first start.
  - Exactly one `done` pulse at cycle 12; no second sweep begins.
  - A `start` on the cycle after `done` begins a new sweep with `err_cnt` cleared to 0.
- **Reset mid-sweep:**
  - Drop `rst_n` during vector 2's SETTLE.
  - Immediately `busy`=0, `a_o`=`b_o`=0, `err_cnt`=0, `pass`=0, and no `done`.
  - A fresh `start` after release yields a full correct sweep with `pass`=1.
- **SETTLE=1 with a gate model registered by one cycle:**
  - `pass`=1.
  - `done` 8 cycles after the start edge.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for the two-input basic-gate block: sweeps ab = 00,01,10,11,
// samples the seven gate outputs, and reports pass/err_cnt. GATE_CHK_MASK_EN adds fail_mask.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       gate_in,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_CHK_MASK_EN
  ,
  output logic [6:0]       fail_mask
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       exp_v, diff;
`ifdef GATE_CHK_MASK_EN
  logic [6:0]       mask_q, mask_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_CHK_MASK_EN
    mask_d  = mask_q;
`endif
    exp_v = {~a_q, ~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
    diff  = gate_in ^ exp_v;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef GATE_CHK_MASK_EN
          mask_d  = '0;
`endif
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if ((|diff) && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
`ifdef GATE_CHK_MASK_EN
        mask_d = mask_q | diff;
`endif
        if (vec_q != 2'd3) begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          cnt_d      = '0;
          state_d    = S_SETTLE;
        end else begin
          // Verdict uses err_d so the last vector counts and pass is valid alongside done.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      S_DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef GATE_CHK_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef GATE_CHK_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_CHK_MASK_EN
  assign fail_mask = mask_q;
`endif

endmodule
